// File: rtl/crossbar_switch_scheduler_pkg.sv
// Shared types and helpers for the crossbar switch scheduler.
// Helpers take the port count as an argument so one package serves every N.
package crossbar_switch_pkg;
   localparam int MAX_N     = 64;
   localparam int MAX_SEL_W = 6;

   typedef logic [MAX_SEL_W-1:0] port_idx_t;

   function automatic int sel_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // (a - b) mod n, n a power of two
   function automatic port_idx_t mod_sub(input port_idx_t a, input port_idx_t b, input int n);
      port_idx_t m;
      m = port_idx_t'(n - 1);
      return (a - b) & m;
   endfunction

   // First set bit of mask scanning cyclically upward from ptr; 0 when mask is empty
   function automatic port_idx_t rr_pick(input logic [MAX_N-1:0] mask, input port_idx_t ptr,
                                         input int n);
      port_idx_t m, idx, pick;
      m    = port_idx_t'(n - 1);
      pick = '0;
      for (int k = MAX_N - 1; k >= 0; k--) begin
         idx = (ptr + port_idx_t'(k)) & m;
         if (k < n && mask[idx]) pick = idx;
      end
      return pick;
   endfunction
endpackage

// File: rtl/crossbar_switch_scheduler_if.sv
// Requester and switch-facing signals of the scheduler.
interface crossbar_switch_scheduler_if
   import crossbar_switch_pkg::*;
#(
   parameter int N = 8
);
   localparam int SEL_W = sel_w(N);

   logic [N-1:0]            req_valid;
   logic [N-1:0][SEL_W-1:0] req_dest;
   logic [N-1:0]            req_last;
   logic                    switch_error;
   logic [N-1:0]            grant;
   logic [N-1:0][SEL_W-1:0] input_sel;
   logic [N-1:0]            output_enable;
   logic                    busy;

   modport master (
      output req_valid, req_dest, req_last, switch_error,
      input  grant, input_sel, output_enable, busy
   );
   modport slave (
      input  req_valid, req_dest, req_last, switch_error,
      output grant, input_sel, output_enable, busy
   );
endinterface

// File: rtl/crossbar_switch_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr.
module crossbar_switch_rr_arbiter
   import crossbar_switch_pkg::*;
#(
   parameter int N = 8,
   localparam int SEL_W = sel_w(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic             gnt_vld,
   output logic [SEL_W-1:0] gnt_idx
);
   logic [MAX_N-1:0] mask;
   port_idx_t        pick;

   always_comb begin
      mask       = '0;
      mask[N-1:0] = req;
      pick       = rr_pick(mask, port_idx_t'(ptr), N);
      gnt_vld    = |req;
      gnt_idx    = SEL_W'(pick);
   end
endmodule

// File: rtl/crossbar_switch_scheduler.sv
// Per-output round-robin scheduler for a crossbar switch; holds each
// connection for a whole packet and flushes all connections on switch error.
module crossbar_switch_scheduler
   import crossbar_switch_pkg::*;
#(
   parameter int N           = 8,
   parameter bit BARREL_ONLY = 1'b1
) (
   input logic                   clk,
   input logic                   rst_n,
   crossbar_switch_scheduler_if.slave bus
);
   localparam int SEL_W = sel_w(N);
   typedef logic [SEL_W-1:0] idx_t;

   logic [N-1:0]          owner_vld;
   idx_t [N-1:0]          owner_idx;
   idx_t [N-1:0]          rr_ptr;
   idx_t                  cur_shift;
   idx_t                  epoch_ptr;

   logic [N-1:0]          grant_w;
   logic                  busy_w;
   logic [N-1:0]          rel;
   logic                  ep_vld;
   idx_t                  ep_idx;
   idx_t                  shift_t;
   logic [N-1:0][N-1:0]   cand;
   logic [N-1:0]          win_vld;
   idx_t [N-1:0]          win_idx;

   always_comb begin
      grant_w = '0;
      for (int j = 0; j < N; j++)
         if (owner_vld[j]) grant_w[owner_idx[j]] = 1'b1;
      busy_w = |owner_vld;
   end

   // Epoch scan picks the shift used by the next batch of connections once idle
   crossbar_switch_rr_arbiter #(.N(N)) u_epoch (
      .req     (bus.req_valid),
      .ptr     (epoch_ptr),
      .gnt_vld (ep_vld),
      .gnt_idx (ep_idx)
   );

   always_comb begin
      shift_t = busy_w ? cur_shift
                       : idx_t'(mod_sub(port_idx_t'(bus.req_dest[ep_idx]), port_idx_t'(ep_idx), N));
      cand = '0;
      rel  = '0;
      for (int j = 0; j < N; j++) begin
         rel[j] = owner_vld[j] & bus.req_valid[owner_idx[j]] & bus.req_last[owner_idx[j]];
         for (int i = 0; i < N; i++)
            cand[j][i] = bus.req_valid[i] & (bus.req_dest[i] == idx_t'(j)) & ~grant_w[i]
                       & ~owner_vld[j] & ~bus.switch_error
                       & (!BARREL_ONLY
                          || idx_t'(mod_sub(port_idx_t'(j), port_idx_t'(i), N)) == shift_t);
      end
   end

   for (genvar j = 0; j < N; j++) begin : g_arb
      crossbar_switch_rr_arbiter #(.N(N)) u_arb (
         .req     (cand[j]),
         .ptr     (rr_ptr[j]),
         .gnt_vld (win_vld[j]),
         .gnt_idx (win_idx[j])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_vld <= '0;
         owner_idx <= '0;
         rr_ptr    <= '0;
         cur_shift <= '0;
         epoch_ptr <= '0;
      end else if (bus.switch_error) begin
         owner_vld <= '0;
      end else begin
         if (!busy_w && ep_vld) begin
            cur_shift <= shift_t;
            epoch_ptr <= ep_idx + 1'b1;
         end
         for (int j = 0; j < N; j++) begin
            if (rel[j]) begin
               owner_vld[j] <= 1'b0;
            end else if (win_vld[j]) begin
               owner_vld[j] <= 1'b1;
               owner_idx[j] <= win_idx[j];
               rr_ptr[j]    <= win_idx[j] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      bus.grant         = grant_w;
      bus.busy          = busy_w;
      bus.output_enable = owner_vld;
      for (int j = 0; j < N; j++)
         bus.input_sel[j] = owner_vld[j] ? owner_idx[j] : '0;
   end
endmodule

// File: tb/tb_crossbar_switch_scheduler.sv
// Scoreboard bench: two N=4 schedulers (free mapping and barrel-only).
module tb_crossbar_switch_scheduler;
   localparam int N = 4;
   typedef logic [3:0][1:0] sel_t;

   typedef struct {
      int         cyc;
      bit         d;
      logic [3:0] g;
      logic [3:0] oe;
      sel_t       sel;
      int         shift;
      string      nm;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   crossbar_switch_scheduler_if #(.N(N)) bus0 ();
   crossbar_switch_scheduler_if #(.N(N)) bus1 ();

   crossbar_switch_scheduler #(.N(N), .BARREL_ONLY(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   crossbar_switch_scheduler #(.N(N), .BARREL_ONLY(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   exp_t sb[$];
   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   function automatic sel_t sl(input int s3, input int s2, input int s1, input int s0);
      return {2'(s3), 2'(s2), 2'(s1), 2'(s0)};
   endfunction

   // Drive one cycle of inputs and queue the outputs expected in that same cycle
   task automatic step(input bit d, input logic [3:0] v, input sel_t dst, input logic [3:0] l,
                       input bit err, input logic [3:0] eg, input logic [3:0] eoe,
                       input sel_t esel, input int esh, input string nm);
      exp_t e;
      if (!d) begin
         bus0.req_valid = v; bus0.req_dest = dst; bus0.req_last = l; bus0.switch_error = err;
      end else begin
         bus1.req_valid = v; bus1.req_dest = dst; bus1.req_last = l; bus1.switch_error = err;
      end
      e.cyc = cyc; e.d = d; e.g = eg; e.oe = eoe; e.sel = esel; e.shift = esh; e.nm = nm;
      sb.push_back(e);
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      exp_t e;
      bit dup, bad;
      if (rst_n) begin
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            if (e.cyc < cyc) chk({e.nm, "_missed"}, cyc, e.cyc);
            else if (!e.d) begin
               chk({e.nm, "_grant"}, bus0.grant, e.g);
               chk({e.nm, "_oe"}, bus0.output_enable, e.oe);
               chk({e.nm, "_sel"}, bus0.input_sel, e.sel);
               chk({e.nm, "_busy"}, bus0.busy, |e.oe);
            end else begin
               chk({e.nm, "_grant"}, bus1.grant, e.g);
               chk({e.nm, "_oe"}, bus1.output_enable, e.oe);
               chk({e.nm, "_sel"}, bus1.input_sel, e.sel);
               chk({e.nm, "_busy"}, bus1.busy, |e.oe);
               if (e.shift >= 0) chk({e.nm, "_shift"}, dut1.cur_shift, e.shift);
            end
         end
         dup = 1'b0;
         bad = 1'b0;
         for (int j = 0; j < N; j++) begin
            for (int k = j + 1; k < N; k++) begin
               if (dut0.owner_vld[j] && dut0.owner_vld[k] && dut0.owner_idx[j] == dut0.owner_idx[k])
                  dup = 1'b1;
               if (dut1.owner_vld[j] && dut1.owner_vld[k] && dut1.owner_idx[j] == dut1.owner_idx[k])
                  dup = 1'b1;
            end
            if (dut1.owner_vld[j] && ((j - int'(dut1.owner_idx[j])) & 3) != int'(dut1.cur_shift))
               bad = 1'b1;
         end
         chk("inv_unique_owner", dup, 0);
         chk("inv_barrel_shift", bad, 0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      sel_t z;
      z = sl(0, 0, 0, 0);
      bus0.req_valid = '0; bus0.req_dest = '0; bus0.req_last = '0; bus0.switch_error = 1'b0;
      bus1.req_valid = '0; bus1.req_dest = '0; bus1.req_last = '0; bus1.switch_error = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_grant0", bus0.grant, 0);
      chk("rst_oe0", bus0.output_enable, 0);
      chk("rst_sel0", bus0.input_sel, 0);
      chk("rst_busy0", bus0.busy, 0);
      chk("rst_grant1", bus1.grant, 0);
      chk("rst_oe1", bus1.output_enable, 0);
      rst_n = 1'b1;

      // single packet i2 -> o1
      step(0, 4'b0100, sl(0, 1, 0, 0), 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "single_c0");
      step(0, 4'b0100, sl(0, 1, 0, 0), 4'b0000, 0, 4'b0100, 4'b0010, sl(0, 0, 2, 0), -1, "single_c1");
      step(0, 4'b0100, sl(0, 1, 0, 0), 4'b0000, 0, 4'b0100, 4'b0010, sl(0, 0, 2, 0), -1, "single_c2");
      step(0, 4'b0100, sl(0, 1, 0, 0), 4'b0100, 0, 4'b0100, 4'b0010, sl(0, 0, 2, 0), -1, "single_c3");
      step(0, 4'b0000, z, 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "single_c4");

      // one-beat packet released in its grant cycle
      step(0, 4'b1000, z, 4'b1000, 0, 4'b0000, 4'b0000, z, -1, "onebeat_c0");
      step(0, 4'b1000, z, 4'b1000, 0, 4'b1000, 4'b0001, sl(0, 0, 0, 3), -1, "onebeat_c1");
      step(0, 4'b0000, z, 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "onebeat_c2");

      // contention i0/i3 -> o2, two-beat packets, strict alternation
      step(0, 4'b1001, sl(2, 0, 0, 2), 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "cont_c0");
      step(0, 4'b1001, sl(2, 0, 0, 2), 4'b0000, 0, 4'b0001, 4'b0100, z, -1, "cont_c1");
      step(0, 4'b1001, sl(2, 0, 0, 2), 4'b0001, 0, 4'b0001, 4'b0100, z, -1, "cont_c2");
      step(0, 4'b1001, sl(2, 0, 0, 2), 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "cont_c3");
      step(0, 4'b1001, sl(2, 0, 0, 2), 4'b0000, 0, 4'b1000, 4'b0100, sl(0, 3, 0, 0), -1, "cont_c4");
      step(0, 4'b1001, sl(2, 0, 0, 2), 4'b1000, 0, 4'b1000, 4'b0100, sl(0, 3, 0, 0), -1, "cont_c5");
      step(0, 4'b1001, sl(2, 0, 0, 2), 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "cont_c6");
      step(0, 4'b1001, sl(2, 0, 0, 2), 4'b0000, 0, 4'b0001, 4'b0100, z, -1, "cont_c7");
      step(0, 4'b1001, sl(2, 0, 0, 2), 4'b0001, 0, 4'b0001, 4'b0100, z, -1, "cont_c8");
      step(0, 4'b0000, z, 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "cont_c9");

      // error flush during a 4-beat packet i0 -> o0, then retransmit
      step(0, 4'b0001, z, 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "err_c0");
      step(0, 4'b0001, z, 4'b0000, 0, 4'b0001, 4'b0001, z, -1, "err_c1");
      step(0, 4'b0001, z, 4'b0000, 1, 4'b0001, 4'b0001, z, -1, "err_c2");
      step(0, 4'b0001, z, 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "err_c3");
      step(0, 4'b0001, z, 4'b0000, 0, 4'b0001, 4'b0001, z, -1, "err_c4");
      step(0, 4'b0001, z, 4'b0000, 0, 4'b0001, 4'b0001, z, -1, "err_c5");
      step(0, 4'b0001, z, 4'b0000, 0, 4'b0001, 4'b0001, z, -1, "err_c6");
      step(0, 4'b0001, z, 4'b0001, 0, 4'b0001, 4'b0001, z, -1, "err_c7");
      step(0, 4'b0000, z, 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "err_c8");

      // dest change and bubble mid-packet i1 -> o3
      step(0, 4'b0010, sl(0, 0, 3, 0), 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "dest_c0");
      step(0, 4'b0010, z, 4'b0000, 0, 4'b0010, 4'b1000, sl(1, 0, 0, 0), -1, "dest_c1");
      step(0, 4'b0000, z, 4'b0000, 0, 4'b0010, 4'b1000, sl(1, 0, 0, 0), -1, "dest_c2");
      step(0, 4'b0010, z, 4'b0010, 0, 4'b0010, 4'b1000, sl(1, 0, 0, 0), -1, "dest_c3");
      step(0, 4'b0000, z, 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "dest_c4");

      // barrel: i0->1, i1->2 share shift 1; i2->0 (shift 2) waits for idle
      step(1, 4'b0111, sl(0, 0, 2, 1), 4'b0000, 0, 4'b0000, 4'b0000, z, 0, "barrel_c0");
      step(1, 4'b0111, sl(0, 0, 2, 1), 4'b0000, 0, 4'b0011, 4'b0110, sl(0, 1, 0, 0), 1, "barrel_c1");
      step(1, 4'b0111, sl(0, 0, 2, 1), 4'b0011, 0, 4'b0011, 4'b0110, sl(0, 1, 0, 0), 1, "barrel_c2");
      step(1, 4'b0100, sl(0, 0, 2, 1), 4'b0000, 0, 4'b0000, 4'b0000, z, 1, "barrel_c3");
      step(1, 4'b0100, sl(0, 0, 2, 1), 4'b0100, 0, 4'b0100, 4'b0001, sl(0, 0, 0, 2), 2, "barrel_c4");
      step(1, 4'b0000, z, 4'b0000, 0, 4'b0000, 4'b0000, z, 2, "barrel_c5");

      // asynchronous reset in the middle of a packet
      step(0, 4'b0100, sl(0, 1, 0, 0), 4'b0000, 0, 4'b0000, 4'b0000, z, -1, "arst_c0");
      step(0, 4'b0100, sl(0, 1, 0, 0), 4'b0000, 0, 4'b0100, 4'b0010, sl(0, 0, 2, 0), -1, "arst_c1");
      #2;
      chk("arst_pre_grant", bus0.grant, 4'b0100);
      rst_n = 1'b0;
      #1;
      chk("arst_grant", bus0.grant, 0);
      chk("arst_oe", bus0.output_enable, 0);
      chk("arst_sel", bus0.input_sel, 0);
      chk("arst_busy", bus0.busy, 0);
      bus0.req_valid = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("scoreboard_drained", sb.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
